// File: rtl/trig_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_seq_pkg : state encoding and default widths for trig_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package trig_seq_pkg;

  localparam int CNT_W_DEFAULT   = 32;
  localparam int PULSE_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    FIRE  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } trig_state_e;

endpackage
`default_nettype wire

// File: rtl/trig_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_seq_if : trigger command / trigger status bundle of trig_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface trig_seq_if #(
  parameter int CNT_W = trig_seq_pkg::CNT_W_DEFAULT
);

  logic             I_start;
  logic [CNT_W-1:0] I_trig_num;
  logic [CNT_W-1:0] I_trig_step;
  logic [CNT_W-1:0] I_wait;
  logic             I_abort;
  logic             O_trig;
  logic [CNT_W-1:0] O_trig_idx;
  logic             O_busy;
  logic             O_done;
  logic             O_overrun;

  modport master (
    output I_start, I_trig_num, I_trig_step, I_wait, I_abort,
    input  O_trig, O_trig_idx, O_busy, O_done, O_overrun
  );

  modport slave (
    input  I_start, I_trig_num, I_trig_step, I_wait, I_abort,
    output O_trig, O_trig_idx, O_busy, O_done, O_overrun
  );

endinterface
`default_nettype wire

// File: rtl/trig_seq_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_seq_cnt : loadable down-counter that saturates at zero
// Rev 1.0
// ----------------------------------------------------------------------------
module trig_seq_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             en_i,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/trig_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_sequencer : delayed, fixed-period train of fixed-width trigger pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module trig_sequencer
  import trig_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int PULSE_W = PULSE_W_DEFAULT
) (
  input  logic       I_clk,
  input  logic       I_rst,
  trig_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] PW    = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] PW_M1 = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             trig_q, busy_q, done_q, ovr_q, ovr_d;
  logic             tmr_load, tmr_en, tmr_zero;
  logic             pw_load, pw_en, pw_zero;
  logic [CNT_W-1:0] tmr_val, step_clamped;
  logic             is_busy;

  assign step_clamped = (bus.I_trig_step < PW) ? PW : bus.I_trig_step;
  assign is_busy      = (state_q == DELAY) || (state_q == FIRE) || (state_q == GAP);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = bus.I_wait - ONE;
    tmr_en   = 1'b0;
    pw_load  = 1'b0;
    pw_en    = 1'b0;
    ovr_d    = is_busy && bus.I_start && !bus.I_abort;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.I_start && !bus.I_abort) begin
          per_d = step_clamped;
          rem_d = bus.I_trig_num - ONE;
          idx_d = '0;
          if (bus.I_trig_num == '0) begin
            state_d = DONE;
          end else if (bus.I_wait == '0) begin
            state_d = FIRE;
            pw_load = 1'b1;
          end else begin
            state_d  = DELAY;
            tmr_load = 1'b1;
          end
        end
      end
      DELAY: begin
        if (bus.I_abort) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          state_d = FIRE;
          pw_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      FIRE: begin
        if (bus.I_abort) begin
          state_d = IDLE;
        end else if (!pw_zero) begin
          pw_en = 1'b1;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          rem_d = rem_q - ONE;
          // A period equal to the pulse width chains pulses with no low gap.
          if (per_q == PW) begin
            pw_load = 1'b1;
            idx_d   = idx_q + ONE;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = per_q - PW - ONE;
          end
        end
      end
      GAP: begin
        if (bus.I_abort) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          state_d = FIRE;
          pw_load = 1'b1;
          idx_d   = idx_q + ONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      trig_q  <= (state_d == FIRE);
      busy_q  <= (state_d == DELAY) || (state_d == FIRE) || (state_d == GAP);
      done_q  <= (state_d == DONE);
      ovr_q   <= ovr_d;
    end
  end

  // Shared timer: delay before the first pulse and low gap between pulses.
  trig_seq_cnt #(.CNT_W(CNT_W)) u_tmr (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .en_i    (tmr_en),
    .zero_o  (tmr_zero)
  );

  trig_seq_cnt #(.CNT_W(CNT_W)) u_pw (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .load_i  (pw_load),
    .value_i (PW_M1),
    .en_i    (pw_en),
    .zero_o  (pw_zero)
  );

  assign bus.O_trig     = trig_q;
  assign bus.O_trig_idx = idx_q;
  assign bus.O_busy     = busy_q;
  assign bus.O_done     = done_q;
  assign bus.O_overrun  = ovr_q;

endmodule
`default_nettype wire
